// File: rtl/sum_capture_pkg.sv
// Shared defaults for the sum capture FIFO: sample/occupancy widths, depth and
// the pointer-width helper used to size the modulo pointers.
package sum_capture_pkg;

  localparam int SC_DATA_W = 9;
  localparam int SC_DEPTH  = 17;
  localparam int SC_CNT_W  = 5;
  localparam int SC_OVF_W  = 8;

  localparam int OVF_MAX = (1 << SC_OVF_W) - 1;

  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/sum_capture_fifo_ptr.sv
// Modulo-DEPTH pointer: advances by one when enabled and wraps from DEPTH-1
// back to 0, so non-power-of-two depths work without masking.
module mod_ptr #(
  parameter int DEPTH = 17,
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sum_capture_fifo.sv
// First-word-fall-through capture FIFO for adder sums, with registered
// full/empty flags and a saturating count of samples dropped while full.
module sum_capture_fifo
  import sum_capture_pkg::*;
#(
  parameter int DATA_W = SC_DATA_W,
  parameter int DEPTH  = SC_DEPTH,
  parameter int CNT_W  = SC_CNT_W,
  parameter int OVF_W  = SC_OVF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic [OVF_W-1:0]  overflow_cnt
);

  localparam int               PTR_W    = clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_nxt;

  // A full FIFO refuses input even when the head is popped the same cycle.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & ~full;
  assign pop       = out_ready & ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr];

  mod_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (push),
    .ptr   (wr_ptr)
  );

  mod_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      overflow_cnt <= '0;
    end else begin
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
      if (in_valid && full && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

endmodule
